fft_frame_sink: RTL and testbench
=================================

Name: fft_frame_sink

Overview:
- Consumer at the output end of the 16-point FFT stream. Accepts the FFT's push/stall sample stream: one complex sample per push, 16 pushes per frame, no frame marker.
- Buffers frames in a two-bank ping-pong store and undoes bit-reversed ordering.
- Emits one power value per bin, |X|^2 = re^2 + im^2, in natural bin order to a downstream push/stall consumer.
- Reports the peak bin of each frame.

Parameters:
- N, 16, points per frame (power of two).
- LOG2N, 4, bin index width.
- DW, 16, signed sample component width.
- BIT_REV, 1: 1 = incoming sample k is stored at bitrev(k); 0 = stored at k.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_push  in  1  sample valid from FFT (connects to FFT out_push_F).
- in_real  in  DW  signed real part.
- in_imag  in  DW  signed imaginary part.
- in_stall  out  1  back-pressure to FFT (connects to FFT out_stall).
- out_push_F  out  1  power sample valid, registered.
- out_bin_F  out  LOG2N  bin index of out_power_F.
- out_power_F  out  2*DW  unsigned re^2+im^2.
- out_stall  in  1  downstream back-pressure.
- peak_valid_F  out  1  one-cycle pulse: peak result valid.
- peak_bin_F  out  LOG2N  bin of maximum power in frame.
- peak_power_F  out  2*DW  maximum power in frame.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous, active-high (reset).
- Reset state:
  - All outputs 0.
  - Both banks empty; wr_bank = rd_bank = 0; wr_idx = rd_idx = 0.
  - Peak tracker cleared.
  - Reset mid-frame discards all partial and full frames.
- Storage: 2 banks x N words of 2*DW bits {re, im}.
- Write side:
  - in_stall = full[wr_bank], driven from registers only, so it is high when the target bank is still occupied.
  - A push with in_stall=0 writes to addr = BIT_REV ? bitrev(wr_idx) : wr_idx, then wr_idx++.
  - On the push with wr_idx = N-1: full[wr_bank] <= 1, wr_bank toggles, wr_idx wraps to 0.
  - A push while in_stall=1 is dropped; no state change.
- Read FSM states IDLE and STREAM:
  - IDLE -> STREAM when full[rd_bank] = 1.
  - In STREAM, each cycle with out_stall=0 issues a read of rd_bank[rd_idx], then rd_idx++.
  - out_stall=1 holds rd_idx; no issue.
  - Issuing rd_idx = N-1 clears full[rd_bank], toggles rd_bank and wraps rd_idx.
  - After that issue: go to STREAM again if the other bank is full (back-to-back frames, no bubble), else IDLE.
- Output timing:
  - Latency is 1 cycle. A read issued in cycle t produces out_push_F=1 with out_bin_F=rd_idx(t) and out_power_F in cycle t+1.
  - out_push_F=0 in any cycle following no issue; out_bin_F/out_power_F hold their last value.
- Arithmetic:
  - re^2 and im^2 are signed DW x DW products.
  - The sum is unsigned 2*DW. Maximum 2*(2^(DW-1))^2 = 2^(2DW-1), which fits; no saturation needed.
- Simultaneous events:
  - A write filling a bank and a read releasing a bank in the same cycle are both honoured; full[] is updated per bank independently.
  - The writer may begin refilling a bank in the cycle after its release.
- Peak tracking:
  - Running max is reset at bin 0 of each frame.
  - Update uses strict greater-than, so ties keep the lower bin.
  - peak_valid_F pulses in the same cycle as out_push_F for bin N-1. peak_bin_F/peak_power_F include bin N-1 and hold until the next pulse.
- Throughput: 1 sample/cycle in and out when unstalled.

Decomposition:
- Shared package: N, LOG2N, DW, the bitrev function, and the {re, im} sample word packing, identical to the FFT memory word: re in [2DW-1:DW], im in [DW-1:0].
- One sub-module, fft_pow_calc: registered re^2+im^2, 1-cycle latency.
- Bank storage is inline register arrays.

Test Plan:
- Single frame, BIT_REV=1: push x[k] = (k, 0) for k=0..15 -> out bins 0..15 in order, power(bin b) = bitrev(b)^2 (bin 1 -> 64, bin 15 -> 225). peak_bin_F=15, peak_power_F=225 with last push.
- Full-scale corner: sample (-32768, -32768) -> out_power_F = 0x80000000. Sample (32767, -32768) -> 0x7FFF0001.
- Back-pressure: hold out_stall=1 while pushing 3 frames -> in_stall rises exactly after 32 accepted pushes. A 33rd push is dropped. Release -> 32 outputs, contiguous, correct values, none lost or duplicated.
- Random out_stall toggling (50%) over 10 frames -> every out_push_F follows an out_stall=0 cycle by 1; output sequence matches the model.
- Peak ties: bins 3 and 9 equal max power 1000 -> peak_bin_F=3.
- Reset after 7 pushes, then one clean frame -> only that frame's 16 outputs appear; all outputs 0 during and immediately after reset.

Source files
------------

// File: rtl/fft_frame_sink_pkg.sv
// Shared types for the FFT output sink: frame geometry, the {re, im} sample word
// (same packing as the FFT memory word) and the bin-index bit reversal.
package fft_frame_sink_pkg;

  localparam int N     = 16;
  localparam int LOG2N = 4;
  localparam int DW    = 16;

  typedef logic [LOG2N-1:0] bin_t;
  typedef logic [2*DW-1:0]  power_t;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } sample_t;

  function automatic bin_t bitrev(input bin_t k);
    bin_t r;
    for (int i = 0; i < LOG2N; i++) r[i] = k[LOG2N-1-i];
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_sink_if.sv
// Push/stall sample stream from the FFT plus the power and peak result outputs.
// master = FFT/downstream side, slave = the frame sink.
interface fft_frame_sink_if;
  import fft_frame_sink_pkg::*;

  logic                 in_push;
  logic signed [DW-1:0] in_real;
  logic signed [DW-1:0] in_imag;
  logic                 in_stall;
  logic                 out_push_F;
  bin_t                 out_bin_F;
  power_t               out_power_F;
  logic                 out_stall;
  logic                 peak_valid_F;
  bin_t                 peak_bin_F;
  power_t               peak_power_F;

  modport master (
    output in_push, in_real, in_imag, out_stall,
    input  in_stall, out_push_F, out_bin_F, out_power_F,
    input  peak_valid_F, peak_bin_F, peak_power_F
  );

  modport slave (
    input  in_push, in_real, in_imag, out_stall,
    output in_stall, out_push_F, out_bin_F, out_power_F,
    output peak_valid_F, peak_bin_F, peak_power_F
  );

endinterface

// File: rtl/fft_frame_sink_pow_calc.sv
// Power stage: registered re^2 + im^2 with 1-cycle latency; bin/power hold when idle.
// The combinational sum is also exported so the peak tracker can align with the output.
module fft_pow_calc
  import fft_frame_sink_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    vld,
  input  bin_t    bin,
  input  sample_t smp,
  output power_t  power,
  output logic    push_F,
  output bin_t    bin_F,
  output power_t  power_F
);

  logic signed [2*DW-1:0] re_x, im_x, re_sq, im_sq;

  // Sign-extend first so the truncated 2*DW product is the exact square.
  assign re_x  = {{DW{smp.re[DW-1]}}, smp.re};
  assign im_x  = {{DW{smp.im[DW-1]}}, smp.im};
  assign re_sq = re_x * re_x;
  assign im_sq = im_x * im_x;
  assign power = $unsigned(re_sq) + $unsigned(im_sq);

  always_ff @(posedge clk) begin
    if (reset) begin
      push_F  <= 1'b0;
      bin_F   <= '0;
      power_F <= '0;
    end else begin
      push_F <= vld;
      if (vld) begin
        bin_F   <= bin;
        power_F <= power;
      end
    end
  end

endmodule

// File: rtl/fft_frame_sink.sv
// Ping-pong frame buffer behind the FFT: un-bit-reverses each frame, streams |X|^2 per
// bin in natural order (1-cycle read latency) and reports the frame's peak bin.
module fft_frame_sink
  import fft_frame_sink_pkg::*;
#(
  parameter bit BIT_REV = 1'b1
) (
  input logic             clk,
  input logic             reset,
  fft_frame_sink_if.slave bus
);

  typedef enum logic {IDLE, STREAM} state_t;

  sample_t mem [2][N];
  logic [1:0] full;
  logic       wr_bank, rd_bank;
  bin_t       wr_idx, rd_idx;
  state_t     state;

  logic    acc, issue, last_wr, last_rd, take;
  bin_t    wr_addr, run_bin;
  sample_t rd_word;
  power_t  power_nxt, run_pow;

  assign bus.in_stall = full[wr_bank];
  assign acc     = bus.in_push && !full[wr_bank];
  assign wr_addr = BIT_REV ? bitrev(wr_idx) : wr_idx;
  assign issue   = (state == STREAM) && !bus.out_stall;
  assign last_wr = acc && (wr_idx == bin_t'(N-1));
  assign last_rd = issue && (rd_idx == bin_t'(N-1));
  assign rd_word = mem[rd_bank][rd_idx];

  always_ff @(posedge clk) begin
    if (acc) mem[wr_bank][wr_addr] <= {bus.in_real, bus.in_imag};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_idx  <= '0;
      rd_idx  <= '0;
      state   <= IDLE;
    end else begin
      if (acc) begin
        wr_idx <= wr_idx + 1'b1;
        if (last_wr) wr_bank <= ~wr_bank;
      end
      // A bank can only be filled while empty and released while full, so the
      // write-side set and read-side clear never target the same bank.
      for (int b = 0; b < 2; b++) begin
        if (last_wr && (wr_bank == b[0]))      full[b] <= 1'b1;
        else if (last_rd && (rd_bank == b[0])) full[b] <= 1'b0;
      end
      case (state)
        IDLE: if (full[rd_bank]) state <= STREAM;
        STREAM: begin
          if (issue) begin
            rd_idx <= rd_idx + 1'b1;
            if (last_rd) begin
              rd_bank <= ~rd_bank;
              state   <= full[~rd_bank] ? STREAM : IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strict greater-than keeps the lower bin on ties; bin 0 restarts the search.
  assign take = (rd_idx == '0) || (power_nxt > run_pow);

  always_ff @(posedge clk) begin
    if (reset) begin
      run_bin          <= '0;
      run_pow          <= '0;
      bus.peak_valid_F <= 1'b0;
      bus.peak_bin_F   <= '0;
      bus.peak_power_F <= '0;
    end else begin
      bus.peak_valid_F <= last_rd;
      if (issue && take) begin
        run_bin <= rd_idx;
        run_pow <= power_nxt;
      end
      if (last_rd) begin
        bus.peak_bin_F   <= take ? rd_idx : run_bin;
        bus.peak_power_F <= take ? power_nxt : run_pow;
      end
    end
  end

  fft_pow_calc u_pow (
    .clk     (clk),
    .reset   (reset),
    .vld     (issue),
    .bin     (rd_idx),
    .smp     (rd_word),
    .power   (power_nxt),
    .push_F  (bus.out_push_F),
    .bin_F   (bus.out_bin_F),
    .power_F (bus.out_power_F)
  );

endmodule

// File: tb/tb_fft_frame_sink.sv
// Directed bench for fft_frame_sink: single frames, full-scale corners, back-pressure,
// random downstream stall, peak ties and mid-frame reset.
module tb_fft_frame_sink;
  import fft_frame_sink_pkg::*;

  typedef logic [N*32-1:0] frame_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fft_frame_sink_if bus ();

  fft_frame_sink #(.BIT_REV(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  int viol   = 0;
  int pviol  = 0;
  int cyc    = 0;
  logic [35:0] q_out[$];
  int          q_cyc[$];
  logic [35:0] q_peak[$];
  frame_t      fq[$];
  logic last_ostall = 1'b1;
  logic rnd = 1'b0;
  logic ostall_fix = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.out_push_F === 1'b1) begin
      q_out.push_back({bus.out_bin_F, bus.out_power_F});
      q_cyc.push_back(cyc);
      if (last_ostall !== 1'b0) viol++;
    end
    if (bus.peak_valid_F === 1'b1) begin
      q_peak.push_back({bus.peak_bin_F, bus.peak_power_F});
      if (!(bus.out_push_F === 1'b1 && bus.out_bin_F === 4'd15)) pviol++;
    end
    last_ostall = bus.out_stall;
  end

  function automatic logic [3:0] brev(input logic [3:0] k);
    return {k[0], k[1], k[2], k[3]};
  endfunction

  function automatic logic [31:0] pw(input logic [31:0] w);
    longint r, i;
    r = longint'($signed(w[31:16]));
    i = longint'($signed(w[15:0]));
    return 32'(r * r + i * i);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_push"}, bus.out_push_F, 0);
    chk({tag, "_bin"}, bus.out_bin_F, 0);
    chk({tag, "_pow"}, bus.out_power_F, 0);
    chk({tag, "_pkv"}, bus.peak_valid_F, 0);
    chk({tag, "_pkb"}, bus.peak_bin_F, 0);
    chk({tag, "_pkp"}, bus.peak_power_F, 0);
    chk({tag, "_istall"}, bus.in_stall, 0);
  endtask

  // One clock: drive at posedge+1, sample in_stall mid-cycle, return after next posedge+1.
  task automatic step(input logic p, input logic [31:0] w, output logic a);
    logic s;
    bus.in_push   = p;
    bus.in_real   = w[31:16];
    bus.in_imag   = w[15:0];
    bus.out_stall = rnd ? 1'($urandom_range(0, 1)) : ostall_fix;
    @(negedge clk);
    s = bus.in_stall;
    @(posedge clk);
    #1;
    a = p && !s;
  endtask

  task automatic idle(input int n);
    logic a;
    repeat (n) step(1'b0, 32'h0, a);
  endtask

  task automatic send_frame(input frame_t f);
    logic a;
    int tries;
    for (int k = 0; k < N; k++) begin
      a = 1'b0;
      tries = 0;
      while (!a && tries < 300) begin
        step(1'b1, f[k*32 +: 32], a);
        tries++;
      end
      chk("send_accept", a, 1);
    end
    bus.in_push = 1'b0;
    fq.push_back(f);
  endtask

  task automatic wait_out(input int n);
    int t;
    t = 0;
    while (q_out.size() < n && t < 2000) begin
      idle(1);
      t++;
    end
    chk("out_avail", q_out.size() >= n, 1);
  endtask

  task automatic check_frame(input string tag);
    frame_t f;
    logic [31:0] e, best;
    logic [3:0] bb;
    logic [35:0] o;
    f = fq.pop_front();
    wait_out(16);
    if (q_out.size() < 16) return;
    best = '0;
    bb = '0;
    for (int b = 0; b < N; b++) begin
      e = pw(f[brev(4'(b))*32 +: 32]);
      o = q_out.pop_front();
      void'(q_cyc.pop_front());
      chk({tag, "_bin"}, o[35:32], b);
      chk({tag, "_pow"}, o[31:0], e);
      if (b == 0 || e > best) begin
        best = e;
        bb = 4'(b);
      end
    end
    chk({tag, "_peak_seen"}, q_peak.size() > 0, 1);
    if (q_peak.size() > 0) begin
      o = q_peak.pop_front();
      chk({tag, "_peak"}, o, {bb, best});
    end
  endtask

  initial begin
    frame_t f, fa, fb;
    logic [35:0] o;
    logic a, last_acc;
    int n_acc, c0, c1;

    bus.in_push = 1'b0;
    bus.in_real = '0;
    bus.in_imag = '0;
    bus.out_stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    reset = 1'b0;
    idle(2);

    // Ramp frame: bin b carries x[bitrev(b)] = (bitrev(b), 0).
    for (int k = 0; k < N; k++) f[k*32 +: 32] = {16'(k), 16'h0};
    send_frame(f);
    wait_out(16);
    o = q_out[1];
    chk("ramp_bin1_pow", o[31:0], 64);
    o = q_out[15];
    chk("ramp_bin15_pow", o[31:0], 225);
    check_frame("ramp");
    chk("ramp_peak_bin", bus.peak_bin_F, 15);
    chk("ramp_peak_pow", bus.peak_power_F, 225);

    // Full-scale corners land on bins 0 and bitrev(1)=8.
    f = '0;
    f[0 +: 32]  = 32'h8000_8000;
    f[32 +: 32] = 32'h7FFF_8000;
    send_frame(f);
    wait_out(16);
    o = q_out[0];
    chk("fs_bin0_pow", o[31:0], 32'h8000_0000);
    o = q_out[8];
    chk("fs_bin8_pow", o[31:0], 32'h7FFF_0001);
    check_frame("fullscale");

    // Back-pressure: both banks fill, the 33rd push must bounce.
    for (int k = 0; k < N; k++) begin
      fa[k*32 +: 32] = {16'(k + 100), 16'(-k)};
      fb[k*32 +: 32] = {16'(3 * k), 16'd7};
    end
    ostall_fix = 1'b1;
    n_acc = 0;
    last_acc = 1'b0;
    for (int i = 0; i < 33; i++) begin
      if (i < 16)      step(1'b1, fa[i*32 +: 32], a);
      else if (i < 32) step(1'b1, fb[(i-16)*32 +: 32], a);
      else             step(1'b1, {16'd999, 16'd999}, a);
      if (a) n_acc++;
      if (i == 32) last_acc = a;
    end
    bus.in_push = 1'b0;
    chk("bp_accepted", n_acc, 32);
    chk("bp_33rd_dropped", last_acc, 0);
    chk("bp_in_stall", bus.in_stall, 1);
    chk("bp_no_output", q_out.size(), 0);
    fq.push_back(fa);
    fq.push_back(fb);
    ostall_fix = 1'b0;
    wait_out(32);
    if (q_cyc.size() >= 32) begin
      c0 = q_cyc[0];
      c1 = q_cyc[31];
      chk("bp_contiguous", c1 - c0, 31);
    end
    check_frame("bp_a");
    check_frame("bp_b");
    chk("bp_drained", q_out.size(), 0);

    // Random downstream stall over ten random frames.
    rnd = 1'b1;
    for (int fr = 0; fr < 10; fr++) begin
      for (int k = 0; k < N; k++) f[k*32 +: 32] = $urandom;
      send_frame(f);
    end
    for (int fr = 0; fr < 10; fr++) check_frame("rand");
    rnd = 1'b0;

    // Tie at power 1000 on bins 3 (x[12]) and 9 (x[9]).
    for (int k = 0; k < N; k++) f[k*32 +: 32] = {16'd1, 16'd0};
    f[12*32 +: 32] = {16'd30, 16'd10};
    f[9*32 +: 32]  = {16'd10, 16'd30};
    send_frame(f);
    check_frame("tie");
    chk("tie_peak_bin", bus.peak_bin_F, 3);
    chk("tie_peak_pow", bus.peak_power_F, 1000);

    // Reset with a partial frame in flight.
    for (int k = 0; k < 7; k++) step(1'b1, {16'd500, 16'(k)}, a);
    bus.in_push = 1'b0;
    reset = 1'b1;
    idle(2);
    chk_zero("rst_during");
    reset = 1'b0;
    idle(1);
    chk_zero("rst_after");
    q_out.delete();
    q_cyc.delete();
    q_peak.delete();
    for (int k = 0; k < N; k++) f[k*32 +: 32] = {16'(-k), 16'(2 * k)};
    send_frame(f);
    check_frame("rst_clean");
    idle(40);
    chk("rst_no_extra", q_out.size(), 0);

    chk("stall_rule", viol, 0);
    chk("peak_align", pviol, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
